// File: rtl/maze_pkg.sv
// Shared types, keycodes, screen geometry and candidate-step helpers for the
// maze game blocks.
package maze_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam logic [10:0] SCREEN_W = 11'd640;
  localparam logic [10:0] SCREEN_H = 11'd480;

  function automatic dir_t decode_key(input logic [7:0] keycode);
    dir_t dir;
    case (keycode)
      KEY_W:   dir = DIR_UP;
      KEY_A:   dir = DIR_LEFT;
      KEY_S:   dir = DIR_DOWN;
      KEY_D:   dir = DIR_RIGHT;
      default: dir = DIR_NONE;
    endcase
    return dir;
  endfunction

  // Decrement that saturates at the top/left screen edge.
  function automatic logic [10:0] step_back(input logic [10:0] pos);
    return (pos == 11'd0) ? 11'd0 : pos - 11'd1;
  endfunction

  // Increment clamped so the whole box (pos .. pos+size-1) stays below limit.
  function automatic logic [10:0] step_fwd(input logic [10:0] pos,
                                           input logic [10:0] size,
                                           input logic [10:0] limit);
    logic [10:0] max_pos;
    max_pos = limit - size;
    return (pos + 11'd1 > max_pos) ? max_pos : pos + 11'd1;
  endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// Brings the asynchronous frame strobe into the clk domain and turns each
// rising edge into a single-cycle pulse.
module frame_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_clk,
  output logic frame_edge
);

  logic [1:0] sync_q;
  logic       prev_q;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], frame_clk};
      prev_q <= sync_q[1];
    end
  end

  assign frame_edge = sync_q[1] & ~prev_q;

endmodule

// File: rtl/player_mover.sv
// Moves the player sprite one pixel per frame, probing the destination box
// for maze walls during the scan and committing at the frame boundary.
module player_mover
  import maze_pkg::*;
#(
  parameter logic [9:0] START_X = 10'd267,
  parameter logic [9:0] START_Y = 10'd187,
  parameter logic [9:0] SIZE    = 10'd4,
  parameter logic [9:0] GOAL_X0 = 10'd366,
  parameter logic [9:0] GOAL_X1 = 10'd374,
  parameter logic [9:0] GOAL_Y0 = 10'd280,
  parameter logic [9:0] GOAL_Y1 = 10'd294
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       is_maze,
  input  logic [7:0] keycode,
  output logic [9:0] PlayerX,
  output logic [9:0] PlayerY,
  output logic       is_player,
  output logic       at_goal
);

  localparam logic ST_PROBE  = 1'b0;
  localparam logic ST_COMMIT = 1'b1;

  localparam logic [10:0] SIZE_W = {1'b0, SIZE};

  logic        state;
  dir_t        dir;
  logic        hit;
  logic        goal_check;
  logic        frame_edge;
  logic [10:0] cand_x;
  logic [10:0] cand_y;
  logic [10:0] draw_x;
  logic [10:0] draw_y;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic        in_cand;
  logic        in_goal;

  frame_edge_sync u_frame_edge_sync (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .frame_clk  (frame_clk),
    .frame_edge (frame_edge)
  );

  assign draw_x = {1'b0, DrawX};
  assign draw_y = {1'b0, DrawY};
  assign pos_x  = {1'b0, PlayerX};
  assign pos_y  = {1'b0, PlayerY};

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    cand_x = pos_x;
    cand_y = pos_y;
    case (dir)
      DIR_UP:    cand_y = step_back(pos_y);
      DIR_DOWN:  cand_y = step_fwd(pos_y, SIZE_W, SCREEN_H);
      DIR_LEFT:  cand_x = step_back(pos_x);
      DIR_RIGHT: cand_x = step_fwd(pos_x, SIZE_W, SCREEN_W);
      default:   ;
    endcase
  end

  assign in_cand = (draw_x >= cand_x) && (draw_x <= cand_x + SIZE_W - 11'd1) &&
                   (draw_y >= cand_y) && (draw_y <= cand_y + SIZE_W - 11'd1);

  assign is_player = (draw_x >= pos_x) && (draw_x <= pos_x + SIZE_W - 11'd1) &&
                     (draw_y >= pos_y) && (draw_y <= pos_y + SIZE_W - 11'd1);

  assign in_goal = (pos_x >= {1'b0, GOAL_X0}) &&
                   (pos_x + SIZE_W - 11'd1 <= {1'b0, GOAL_X1}) &&
                   (pos_y >= {1'b0, GOAL_Y0}) &&
                   (pos_y + SIZE_W - 11'd1 <= {1'b0, GOAL_Y1});

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_PROBE;
      dir        <= DIR_NONE;
      hit        <= 1'b0;
      goal_check <= 1'b0;
      PlayerX    <= START_X;
      PlayerY    <= START_Y;
      at_goal    <= 1'b0;
    end else begin
      goal_check <= (state == ST_COMMIT);
      if (goal_check && in_goal)
        at_goal <= 1'b1;

      case (state)
        ST_PROBE: begin
          // A wall seen in the same cycle as the frame edge still counts.
          if (is_maze && in_cand)
            hit <= 1'b1;
          if (frame_edge)
            state <= ST_COMMIT;
        end
        default: begin
          if (dir != DIR_NONE && !hit && !at_goal) begin
            PlayerX <= cand_x[9:0];
            PlayerY <= cand_y[9:0];
          end
          dir   <= decode_key(keycode);
          hit   <= 1'b0;
          state <= ST_PROBE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_mover.sv
// Directed bench: a wall-probing main instance plus saturation and goal
// instances driven by a windowed raster scan.
module tb_player_mover;
  import maze_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_clk;
  logic [9:0] draw_x;
  logic [9:0] draw_y;
  logic [7:0] key_main;
  logic [7:0] key_aux;
  logic       maze_main;

  logic [9:0] px_m, py_m, px_s, py_s, px_g, py_g;
  logic       ip_m, ip_s, ip_g, g_m, g_s, g_g;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Wall occupying columns 275..280 on every row.
  assign maze_main = (draw_x >= 10'd275) && (draw_x <= 10'd280);

  player_mover u_main (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk),
    .DrawX(draw_x), .DrawY(draw_y), .is_maze(maze_main), .keycode(key_main),
    .PlayerX(px_m), .PlayerY(py_m), .is_player(ip_m), .at_goal(g_m)
  );

  player_mover #(.START_X(10'd0), .START_Y(10'd476)) u_sat (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk),
    .DrawX(draw_x), .DrawY(draw_y), .is_maze(1'b0), .keycode(key_aux),
    .PlayerX(px_s), .PlayerY(py_s), .is_player(ip_s), .at_goal(g_s)
  );

  player_mover #(.START_X(10'd366), .START_Y(10'd290)) u_goal (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk),
    .DrawX(draw_x), .DrawY(draw_y), .is_maze(1'b0), .keycode(key_aux),
    .PlayerX(px_g), .PlayerY(py_g), .is_player(ip_g), .at_goal(g_g)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scan a window around the main player, switching key_main halfway, then
  // strobe frame_clk long enough for the edge, commit and goal update.
  task automatic run_frame(input logic [7:0] k_first, input logic [7:0] k_second);
    key_main = k_first;
    for (int y = 180; y <= 200; y++) begin
      for (int x = 260; x <= 290; x++) begin
        @(negedge clk);
        draw_x = 10'(x);
        draw_y = 10'(y);
        if (y == 190 && x == 260) key_main = k_second;
      end
    end
    @(negedge clk);
    draw_x    = 10'd0;
    draw_y    = 10'd0;
    frame_clk = 1'b1;
    repeat (8) @(negedge clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic probe_pixel(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    draw_x = x;
    draw_y = y;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    frame_clk = 1'b0;
    draw_x    = 10'd0;
    draw_y    = 10'd0;
    key_main  = 8'h00;
    key_aux   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_main_x", 32'(px_m), 32'd267);
    check("reset_main_y", 32'(py_m), 32'd187);
    check("reset_main_goal", 32'(g_m), 32'd0);
    check("reset_sat_x", 32'(px_s), 32'd0);
    check("reset_sat_y", 32'(py_s), 32'd476);
    check("reset_goal_flag", 32'(g_g), 32'd0);

    rst_n   = 1'b1;
    key_aux = KEY_A;

    run_frame(KEY_D, KEY_D);
    check("f1_main_x_no_move", 32'(px_m), 32'd267);
    check("f1_goal_set", 32'(g_g), 32'd1);
    check("f1_goal_x", 32'(px_g), 32'd366);
    check("f1_sat_x", 32'(px_s), 32'd0);

    run_frame(KEY_D, KEY_D);
    check("f2_main_x", 32'(px_m), 32'd268);
    check("f2_main_y", 32'(py_m), 32'd187);
    check("f2_goal_frozen_x", 32'(px_g), 32'd366);
    check("f2_sat_x_no_wrap", 32'(px_s), 32'd0);

    run_frame(KEY_D, KEY_D);
    check("f3_main_x", 32'(px_m), 32'd269);
    key_aux = KEY_S;
    run_frame(KEY_D, KEY_D);
    run_frame(KEY_D, KEY_D);
    check("f5_main_x_at_wall", 32'(px_m), 32'd271);

    run_frame(KEY_D, KEY_D);
    check("f6_main_x_blocked", 32'(px_m), 32'd271);
    check("f6_sat_y_saturated", 32'(py_s), 32'd476);
    check("f6_sat_x", 32'(px_s), 32'd0);
    check("f6_goal_y_frozen", 32'(py_g), 32'd290);
    check("f6_goal_x_frozen", 32'(px_g), 32'd366);

    run_frame(KEY_D, KEY_D);
    check("f7_main_x_blocked", 32'(px_m), 32'd271);
    check("f7_sat_y_saturated", 32'(py_s), 32'd476);

    run_frame(KEY_S, KEY_W);
    check("f8_main_x", 32'(px_m), 32'd271);
    check("f8_main_y_no_move", 32'(py_m), 32'd187);

    run_frame(KEY_W, KEY_D);
    check("f9_main_y_up", 32'(py_m), 32'd186);
    check("f9_main_x", 32'(px_m), 32'd271);

    run_frame(KEY_D, KEY_D);
    check("f10_main_x_blocked", 32'(px_m), 32'd271);
    check("f10_main_y", 32'(py_m), 32'd186);
    check("f10_goal_still_set", 32'(g_g), 32'd1);

    probe_pixel(10'd271, 10'd186);
    check("isp_top_left", 32'(ip_m), 32'd1);
    probe_pixel(10'd274, 10'd189);
    check("isp_bottom_right", 32'(ip_m), 32'd1);
    probe_pixel(10'd275, 10'd189);
    check("isp_right_outside", 32'(ip_m), 32'd0);
    probe_pixel(10'd271, 10'd190);
    check("isp_below_outside", 32'(ip_m), 32'd0);
    probe_pixel(10'd270, 10'd186);
    check("isp_left_outside", 32'(ip_m), 32'd0);
    probe_pixel(10'd272, 10'd185);
    check("isp_above_outside", 32'(ip_m), 32'd0);
    probe_pixel(10'd366, 10'd290);
    check("isp_goal_inst", 32'(ip_g), 32'd1);
    probe_pixel(10'd3, 10'd479);
    check("isp_sat_corner", 32'(ip_s), 32'd1);
    probe_pixel(10'd0, 10'd475);
    check("isp_sat_above", 32'(ip_s), 32'd0);

    // Reset partway through a frame scan.
    key_main = KEY_D;
    for (int x = 260; x < 280; x++) begin
      @(negedge clk);
      draw_x = 10'(x);
      draw_y = 10'd187;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_main_x", 32'(px_m), 32'd267);
    check("midreset_main_y", 32'(py_m), 32'd187);
    check("midreset_goal_flag", 32'(g_g), 32'd0);
    check("midreset_goal_x", 32'(px_g), 32'd366);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_frame(KEY_D, KEY_D);
    check("postreset_main_x", 32'(px_m), 32'd267);
    check("postreset_goal_set", 32'(g_g), 32'd1);
    run_frame(KEY_D, KEY_D);
    check("postreset_main_x_move", 32'(px_m), 32'd268);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
